// File: rtl/pulse_meter.sv
// pulse_meter: measures high-pulse width in clock cycles and hands results to a ready/valid consumer
module pulse_meter #(
  parameter int CW = 16,
  parameter int NW = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          sig_in,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [CW-1:0] width,
  output logic          sat,
  output logic          drop,
  output logic [NW-1:0] pulse_cnt
);
  typedef enum logic {IDLE, MEASURE} state_t;
  localparam logic [CW-1:0] MAX = '1;
  state_t state, state_nxt;
  logic prev, sat_int, sat_int_nxt, rise, fall, done, load;
  logic [CW-1:0] cnt, cnt_nxt;
  assign rise = sig_in & ~prev;
  assign fall = ~sig_in & prev;
  assign load = done & (~out_valid | out_ready);
  // state register
  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nxt;
  // next state and measurement counter; a pulse starts at 1 because the rising sample itself is high
  always_comb begin
    state_nxt = state;
    cnt_nxt = cnt;
    sat_int_nxt = sat_int;
    done = 1'b0;
    case (state)
      IDLE: if (rise) begin
        state_nxt = MEASURE;
        cnt_nxt = CW'(1);
        sat_int_nxt = 1'b0;
      end
      MEASURE: if (sig_in) begin
        cnt_nxt = (cnt == MAX) ? MAX : cnt + CW'(1);
        sat_int_nxt = sat_int | (cnt >= MAX - CW'(1));
      end else if (fall) begin
        state_nxt = IDLE;
        done = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end
  // datapath: edge history, counter, output slot, drop strobe and completed-pulse count
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      prev <= 1'b1;
      cnt <= '0;
      sat_int <= 1'b0;
      out_valid <= 1'b0;
      width <= '0;
      sat <= 1'b0;
      drop <= 1'b0;
      pulse_cnt <= '0;
    end else begin
      prev <= sig_in;
      cnt <= cnt_nxt;
      sat_int <= sat_int_nxt;
      drop <= done & ~load;
      out_valid <= load | (out_valid & ~out_ready);
      if (done) pulse_cnt <= pulse_cnt + NW'(1);
      if (load) begin
        width <= cnt;
        sat <= sat_int;
      end
    end
endmodule

// File: tb/tb_pulse_meter.sv
// tb_pulse_meter: directed scenarios for pulse_meter with hand-computed expectations
module tb_pulse_meter;
  logic clock = 1'b0, reset = 1'b0, sig_in = 1'b0, out_ready = 1'b0;
  logic out_valid, sat, drop, out_valid4, sat4, drop4;
  logic [15:0] width;
  logic [3:0] width4;
  logic [7:0] pulse_cnt, pulse_cnt4;
  int checks = 0, errors = 0;

  pulse_meter dut (.clock(clock), .reset(reset), .sig_in(sig_in), .out_ready(out_ready),
    .out_valid(out_valid), .width(width), .sat(sat), .drop(drop), .pulse_cnt(pulse_cnt));
  pulse_meter #(.CW(4), .NW(8)) dut4 (.clock(clock), .reset(reset), .sig_in(sig_in), .out_ready(out_ready),
    .out_valid(out_valid4), .width(width4), .sat(sat4), .drop(drop4), .pulse_cnt(pulse_cnt4));

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL timeout reached");
    $fatal(1);
  end

  task automatic step(input logic s, input logic r);
    sig_in = s;
    out_ready = r;
    @(negedge clock);
  endtask

  task automatic apply_reset;
    reset = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_reset;
    sig_in = 1'b0;
    out_ready = 1'b0;
    reset = 1'b0;
    @(negedge clock);
    @(negedge clock);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
    checks++; if (width !== 16'd0) begin errors++; $display("FAIL reset_width got %0d want 0", width); end
    checks++; if (sat !== 1'b0) begin errors++; $display("FAIL reset_sat got %b want 0", sat); end
    checks++; if (drop !== 1'b0) begin errors++; $display("FAIL reset_drop got %b want 0", drop); end
    checks++; if (pulse_cnt !== 8'd0) begin errors++; $display("FAIL reset_pcnt got %0d want 0", pulse_cnt); end
    checks++; if (out_valid4 !== 1'b0) begin errors++; $display("FAIL reset_valid4 got %b want 0", out_valid4); end
    reset = 1'b1;
  endtask

  task automatic test_basic;
    step(0, 0); step(0, 0);
    for (int i = 0; i < 5; i++) step(1, 0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %b want 0", out_valid); end
    step(0, 0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b want 1", out_valid); end
    checks++; if (width !== 16'd5) begin errors++; $display("FAIL basic_width got %0d want 5", width); end
    checks++; if (sat !== 1'b0) begin errors++; $display("FAIL basic_sat got %b want 0", sat); end
    checks++; if (pulse_cnt !== 8'd1) begin errors++; $display("FAIL basic_pcnt got %0d want 1", pulse_cnt); end
  endtask

  task automatic test_drop;
    apply_reset;
    step(0, 0);
    for (int i = 0; i < 3; i++) step(1, 0);
    step(0, 0);
    checks++; if (width !== 16'd3) begin errors++; $display("FAIL drop_first_width got %0d want 3", width); end
    checks++; if (drop !== 1'b0) begin errors++; $display("FAIL drop_first_drop got %b want 0", drop); end
    for (int i = 0; i < 4; i++) step(1, 0);
    checks++; if (drop !== 1'b0) begin errors++; $display("FAIL drop_early got %b want 0", drop); end
    step(0, 0);
    checks++; if (drop !== 1'b1) begin errors++; $display("FAIL drop_pulse got %b want 1", drop); end
    checks++; if (width !== 16'd3) begin errors++; $display("FAIL drop_width got %0d want 3", width); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL drop_valid got %b want 1", out_valid); end
    checks++; if (pulse_cnt !== 8'd2) begin errors++; $display("FAIL drop_pcnt got %0d want 2", pulse_cnt); end
    step(0, 0);
    checks++; if (drop !== 1'b0) begin errors++; $display("FAIL drop_one_cycle got %b want 0", drop); end
  endtask

  task automatic test_handshake_fall;
    apply_reset;
    step(0, 0);
    for (int i = 0; i < 3; i++) step(1, 0);
    step(0, 0);
    step(0, 0);
    for (int i = 0; i < 6; i++) step(1, 0);
    step(0, 1);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL hs_valid got %b want 1", out_valid); end
    checks++; if (width !== 16'd6) begin errors++; $display("FAIL hs_width got %0d want 6", width); end
    checks++; if (drop !== 1'b0) begin errors++; $display("FAIL hs_drop got %b want 0", drop); end
    checks++; if (pulse_cnt !== 8'd2) begin errors++; $display("FAIL hs_pcnt got %0d want 2", pulse_cnt); end
    step(0, 1);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL hs_clear got %b want 0", out_valid); end
    checks++; if (width !== 16'd6) begin errors++; $display("FAIL hs_hold_width got %0d want 6", width); end
  endtask

  task automatic test_saturate;
    apply_reset;
    step(0, 0);
    for (int i = 0; i < 20; i++) step(1, 0);
    step(0, 0);
    checks++; if (width4 !== 4'd15) begin errors++; $display("FAIL sat4_width got %0d want 15", width4); end
    checks++; if (sat4 !== 1'b1) begin errors++; $display("FAIL sat4_sat got %b want 1", sat4); end
    checks++; if (out_valid4 !== 1'b1) begin errors++; $display("FAIL sat4_valid got %b want 1", out_valid4); end
    checks++; if (width !== 16'd20) begin errors++; $display("FAIL sat16_width got %0d want 20", width); end
    checks++; if (sat !== 1'b0) begin errors++; $display("FAIL sat16_sat got %b want 0", sat); end
  endtask

  task automatic test_high_at_release;
    sig_in = 1'b1;
    apply_reset;
    for (int i = 0; i < 4; i++) step(1, 0);
    step(0, 0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rel_no_valid got %b want 0", out_valid); end
    checks++; if (pulse_cnt !== 8'd0) begin errors++; $display("FAIL rel_pcnt got %0d want 0", pulse_cnt); end
    step(1, 0); step(1, 0);
    step(0, 0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rel_valid got %b want 1", out_valid); end
    checks++; if (width !== 16'd2) begin errors++; $display("FAIL rel_width got %0d want 2", width); end
    checks++; if (pulse_cnt !== 8'd1) begin errors++; $display("FAIL rel_pcnt2 got %0d want 1", pulse_cnt); end
  endtask

  task automatic test_async_reset;
    apply_reset;
    step(0, 0); step(1, 0); step(1, 0); step(0, 0);
    checks++; if (width !== 16'd2) begin errors++; $display("FAIL ar_pre_width got %0d want 2", width); end
    step(1, 0); step(1, 0);
    #2 reset = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ar_valid got %b want 0", out_valid); end
    checks++; if (width !== 16'd0) begin errors++; $display("FAIL ar_width got %0d want 0", width); end
    checks++; if (pulse_cnt !== 8'd0) begin errors++; $display("FAIL ar_pcnt got %0d want 0", pulse_cnt); end
    checks++; if (drop !== 1'b0 || sat !== 1'b0) begin errors++; $display("FAIL ar_drop_sat got %b%b want 00", drop, sat); end
    @(negedge clock);
    reset = 1'b1;
    step(1, 0); step(1, 0); step(0, 0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ar_after_valid got %b want 0", out_valid); end
    checks++; if (pulse_cnt !== 8'd0) begin errors++; $display("FAIL ar_after_pcnt got %0d want 0", pulse_cnt); end
    step(1, 0); step(0, 0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ar_fresh_valid got %b want 1", out_valid); end
    checks++; if (width !== 16'd1) begin errors++; $display("FAIL ar_fresh_width got %0d want 1", width); end
  endtask

  task automatic test_back_to_back;
    apply_reset;
    step(0, 1); step(1, 1); step(1, 1); step(0, 1);
    checks++; if (out_valid !== 1'b1 || width !== 16'd2) begin errors++; $display("FAIL b2b_first got v=%b w=%0d want v=1 w=2", out_valid, width); end
    step(1, 1);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_clear got %b want 0", out_valid); end
    step(0, 1);
    checks++; if (out_valid !== 1'b1 || width !== 16'd1) begin errors++; $display("FAIL b2b_second got v=%b w=%0d want v=1 w=1", out_valid, width); end
    checks++; if (pulse_cnt !== 8'd2) begin errors++; $display("FAIL b2b_pcnt got %0d want 2", pulse_cnt); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_drop;
    test_handshake_fall;
    test_saturate;
    test_high_at_release;
    test_async_reset;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pulse_meter.md
PULSE_METER -- requirements
Module: pulse_meter

Interface
REQ-001 The block SHALL have parameter CW, default 16, giving the width of the pulse-width counter and result.
REQ-002 The block SHALL have parameter NW, default 8, giving the width of the completed-pulse counter.
REQ-003 Port clock, input, 1: single clock; all state SHALL update on its rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-low reset; while low, all state SHALL be held at reset values.
REQ-005 Port sig_in, input, 1: filtered, clock-synchronous level from the upstream glitch filter; no synchronizer SHALL be inserted.
REQ-006 Port out_ready, input, 1: consumer accepts the result when high together with out_valid.
REQ-007 Port out_valid, output, 1: high when width/sat hold an unconsumed result.
REQ-008 Port width, output, CW: high-pulse width in clock cycles.
REQ-009 Port sat, output, 1: the pulse width reached 2^CW-1 and the count saturated.
REQ-010 Port drop, output, 1: one-cycle pulse when a completed measurement is discarded.
REQ-011 Port pulse_cnt, output, NW: count of completed pulses (published or dropped), modulo 2^NW.

Function
REQ-012 The block SHALL register the previous sample as prev; rise = sig_in & ~prev; fall = ~sig_in & prev.
REQ-013 The FSM SHALL have states IDLE and MEASURE; IDLE is the reset state.
REQ-014 IDLE: on rise -> MEASURE with cnt <= 1 and sat_int <= 0; otherwise remain in IDLE with cnt unchanged.
REQ-015 MEASURE with sig_in high: cnt SHALL increment by 1, saturating at 2^CW-1; sat_int SHALL be set on the cycle cnt reaches 2^CW-1 and SHALL stay set.
REQ-016 MEASURE on fall: the FSM SHALL return to IDLE and pulse_cnt SHALL increment, wrapping from 2^NW-1 to 0.
REQ-017 Reported width SHALL equal the number of rising clock edges at which sig_in was sampled high during the pulse.
REQ-018 On fall, if the output slot is free (out_valid low, or out_valid & out_ready in the same cycle), the block SHALL load width <= cnt, sat <= sat_int, and out_valid <= 1 on that edge.
REQ-019 On fall with the slot occupied and not consumed that cycle, the measurement SHALL be discarded, drop SHALL be high for exactly the next cycle, and the held result SHALL be unchanged.
REQ-020 Latency: out_valid SHALL rise on the clock edge that samples the fall, so it is visible 1 cycle after the last high sample.
REQ-021 While out_valid is high, width and sat SHALL remain stable until the handshake (out_valid & out_ready) completes.
REQ-022 A handshake with no simultaneous fall SHALL clear out_valid on that edge.
REQ-023 A handshake coinciding with a fall SHALL load the new result, keep out_valid high, and leave drop low.
REQ-024 Back-to-back pulses (a fall followed by a rise on the next sample) SHALL both be measured; a 1-cycle high pulse SHALL report width 1.
REQ-025 When out_valid is low, width and sat SHALL keep their last loaded values.

Reset
REQ-026 While reset is low: state = IDLE, cnt = 0, sat_int = 0, out_valid = 0, width = 0, sat = 0, drop = 0, pulse_cnt = 0, prev = 1.
REQ-027 Because prev resets to 1, a pulse already high at reset release SHALL NOT be measured; measurement SHALL begin only after sig_in is sampled low.
REQ-028 Reset asserted mid-pulse or with out_valid high SHALL abandon the measurement and held result without asserting drop.

Verification
REQ-029 Bench SHALL check: reset release, sig_in low 2 cycles, high 5 cycles, then low -> out_valid rises 1 cycle after the last high sample, width = 5, sat = 0, pulse_cnt = 1.
REQ-030 Bench SHALL check: out_ready held low; pulses of 3 then 4 cycles -> width stays 3, drop pulses 1 cycle at the second fall, pulse_cnt = 2.
REQ-031 Bench SHALL check: out_ready rises on the same edge as the fall of a 6-cycle pulse while the first result (3) is held -> 3 is consumed, 6 is loaded, out_valid stays 1, drop = 0.
REQ-032 Bench SHALL check: with CW = 4, a 20-cycle pulse -> width = 15, sat = 1.
REQ-033 Bench SHALL check: sig_in high at reset release for 4 cycles, then low 1 cycle, then high 2 cycles -> only width = 2 is reported.
REQ-034 Bench SHALL check: reset asserted asynchronously mid-pulse and mid-clock -> all outputs read 0 immediately, and there is no output after release until a fresh low-to-high transition.
